// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the default geometry, the derived address-field widths, the refill
// FSM state type and the reset vector shared with the program counter.
package icache_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int LINE_WORDS  = 4;
  localparam int NUM_LINES   = 16;

  // Address split: | tag | index | offset | byte(2) |
  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  localparam int INDEX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS    = ADDR_W - OFFSET_BITS - INDEX_BITS - 2;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  // First fetch address after reset; the PC starts here.
  localparam logic [31:0] RESET_PC = 32'd16;

endpackage

// File: rtl/icache_fetch_r32i_refill_ctrl.sv
// Refill controller for the instruction cache.
// Owns the IDLE/REFILL FSM, the word counter, the latched line base, the
// deferred-flush flag and the memory request/address outputs.
//
// Ports:
//   clock, reset     : clock, asynchronous active-high reset
//   lookup_miss      : lookup result for the current fetch (meaningful in IDLE)
//   start_base       : line base of the current fetch (offset and byte bits zero)
//   flush            : one-cycle invalidate-all request
//   mem_ack          : one-cycle acknowledge per refill word
//   state            : current FSM state (also used as a debug view)
//   cnt              : word currently being refilled
//   fill_index       : cache index of the line being refilled
//   fill_tag         : tag of the line being refilled
//   mem_req/mem_addr : refill request and word address
//   fill_write       : write MemRdata into data[fill_index][cnt] this cycle
//   fill_last        : last word of the line arrives this cycle (write tag)
//   fill_validate    : set valid[fill_index] at this edge
//   clear_all        : clear every valid bit at this edge
//
// Memory handshake: mem_req is high for the whole refill; mem_addr only
// changes on a cycle where mem_ack is high, so it is stable while waiting.
// A word is transferred on every clock edge with mem_req && mem_ack, and
// mem_req drops the cycle after the last ack.
module icache_fetch_r32i_refill_ctrl
  import icache_pkg::*;
#(
  parameter int addrW     = 32,
  parameter int LineWords = 4,
  parameter int NumLines  = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 lookup_miss,
  input  logic [addrW-1:0]                     start_base,
  input  logic                                 flush,
  input  logic                                 mem_ack,
  output icache_state_t                        state,
  output logic [$clog2(LineWords)-1:0]         cnt,
  output logic [$clog2(NumLines)-1:0]          fill_index,
  output logic [addrW-$clog2(LineWords)-$clog2(NumLines)-3:0] fill_tag,
  output logic                                 mem_req,
  output logic [addrW-1:0]                     mem_addr,
  output logic                                 fill_write,
  output logic                                 fill_last,
  output logic                                 fill_validate,
  output logic                                 clear_all
);

  localparam int OFF_W = $clog2(LineWords);
  localparam int IDX_W = $clog2(NumLines);
  localparam int TAG_W = addrW - OFF_W - IDX_W - 2;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LineWords - 1);

  icache_state_t    state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [addrW-1:0] base_q, base_d;
  logic             pending_q, pending_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    pending_d     = pending_q;
    mem_req       = 1'b0;
    mem_addr      = '0;
    fill_write    = 1'b0;
    fill_last     = 1'b0;
    fill_validate = 1'b0;
    clear_all     = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush here takes effect at this edge, so a refill started in the
        // same cycle lands after it and is allowed to validate its line.
        if (flush) clear_all = 1'b1;
        if (lookup_miss) begin
          state_d = REFILL;
          base_d  = start_base;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = base_q + addrW'({cnt_q, 2'b00});
        if (flush) pending_d = 1'b1;
        if (mem_ack) begin
          fill_write = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            fill_last = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
            pending_d = 1'b0;
            // A flush seen during the refill (including this last cycle)
            // discards the new line along with everything else.
            if (pending_q || flush) clear_all = 1'b1;
            else                    fill_validate = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state      = state_q;
  assign cnt        = cnt_q;
  assign fill_index = base_q[OFF_W+2 +: IDX_W];
  assign fill_tag   = base_q[addrW-1 -: TAG_W];

endmodule

// File: rtl/icache_fetch_r32i.sv
// Direct-mapped, read-only instruction cache answering PC fetches.
// A hit returns the word combinationally in the same cycle; a miss raises
// InsCacheStall at once and refills the whole line from backing memory.
//
// Ports:
//   clock, reset    : clock, asynchronous active-high reset
//   ProgAddr        : fetch address (bits [1:0] ignored)
//   Flush           : one-cycle pulse, invalidate all lines (fence.i)
//   Instruction     : fetched word, valid when InsCacheStall = 0 (else 0)
//   InsCacheStall   : high while the instruction is not available
//   MemReq/MemAddr  : refill word request and word-aligned address
//   MemRdata/MemAck : refill data, valid on the one-cycle acknowledge
module icache_fetch_r32i
  import icache_pkg::*;
#(
  parameter int dataW     = DATA_W,
  parameter int addrW     = ADDR_W,
  parameter int LineWords = LINE_WORDS,
  parameter int NumLines  = NUM_LINES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [addrW-1:0] ProgAddr,
  input  logic             Flush,
  output logic [dataW-1:0] Instruction,
  output logic             InsCacheStall,
  output logic             MemReq,
  output logic [addrW-1:0] MemAddr,
  input  logic [dataW-1:0] MemRdata,
  input  logic             MemAck
);

  localparam int OFF_W = $clog2(LineWords);
  localparam int IDX_W = $clog2(NumLines);
  localparam int TAG_W = addrW - OFF_W - IDX_W - 2;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [1:0]       unused_byte_bits;

  assign offset           = ProgAddr[OFF_W+1:2];
  assign index            = ProgAddr[OFF_W+2 +: IDX_W];
  assign tag              = ProgAddr[addrW-1 -: TAG_W];
  assign unused_byte_bits = ProgAddr[1:0];

  // Only valid is reset; tag and data are qualified by it.
  logic [NumLines-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NumLines];
  logic [dataW-1:0]    data_q [NumLines][LineWords];

  icache_state_t    state;
  logic [OFF_W-1:0] cnt;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_write, fill_last, fill_validate, clear_all;
  logic             line_match, hit;

  assign line_match    = valid_q[index] && (tag_q[index] == tag);
  assign hit           = (state == IDLE) && line_match;
  assign InsCacheStall = !hit;
  assign Instruction   = hit ? data_q[index][offset] : '0;

  icache_fetch_r32i_refill_ctrl #(
    .addrW     (addrW),
    .LineWords (LineWords),
    .NumLines  (NumLines)
  ) u_refill_ctrl (
    .clock         (clock),
    .reset         (reset),
    .lookup_miss   (!line_match),
    .start_base    ({ProgAddr[addrW-1:OFF_W+2], {(OFF_W+2){1'b0}}}),
    .flush         (Flush),
    .mem_ack       (MemAck),
    .state         (state),
    .cnt           (cnt),
    .fill_index    (fill_index),
    .fill_tag      (fill_tag),
    .mem_req       (MemReq),
    .mem_addr      (MemAddr),
    .fill_write    (fill_write),
    .fill_last     (fill_last),
    .fill_validate (fill_validate),
    .clear_all     (clear_all)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              valid_q <= '0;
    else if (clear_all)     valid_q <= '0;
    else if (fill_validate) valid_q[fill_index] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (fill_write) data_q[fill_index][cnt] <= MemRdata;
    if (fill_last)  tag_q[fill_index]       <= fill_tag;
  end

endmodule

// File: tb/tb_icache_fetch_r32i.sv
// Bench for icache_fetch_r32i: table of fetch vectors plus hand-written
// sequences for slow memory, flush and reset corner cases.
module tb_icache_fetch_r32i;
  import icache_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ProgAddr;
  logic        Flush;
  logic [31:0] Instruction;
  logic        InsCacheStall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemRdata;
  logic        MemAck;

  always #5 clock = ~clock;

  icache_fetch_r32i dut (
    .clock         (clock),
    .reset         (reset),
    .ProgAddr      (ProgAddr),
    .Flush         (Flush),
    .Instruction   (Instruction),
    .InsCacheStall (InsCacheStall),
    .MemReq        (MemReq),
    .MemAddr       (MemAddr),
    .MemRdata      (MemRdata),
    .MemAck        (MemAck)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h10 && a <= 32'h1C)   return 32'hA0 + ((a - 32'h10) >> 2);
    if (a >= 32'h110 && a <= 32'h11C) return 32'hB0 + ((a - 32'h110) >> 2);
    return a ^ 32'hDEAD_0000;
  endfunction

  int          mem_lat = 0;
  int          wait_cnt = 0;
  int          ack_count = 0;
  int          addr_unstable = 0;
  logic        waiting = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] addr_log[$];

  initial begin
    MemAck   = 1'b0;
    MemRdata = '0;
    forever begin
      @(negedge clock);
      if (MemReq && !reset) begin
        if (waiting && MemAddr !== prev_addr) addr_unstable++;
        if (wait_cnt == mem_lat) begin
          MemAck   = 1'b1;
          MemRdata = mem_word(MemAddr);
          addr_log.push_back(MemAddr);
          ack_count++;
          wait_cnt = 0;
          waiting  = 1'b0;
        end else begin
          MemAck    = 1'b0;
          wait_cnt++;
          waiting   = 1'b1;
          prev_addr = MemAddr;
        end
      end else begin
        MemAck   = 1'b0;
        wait_cnt = 0;
        waiting  = 1'b0;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Refill addresses seen by memory must be the line base and the next words.
  task automatic check_log(input string name, input logic [31:0] base);
    logic [31:0] exp_q[$];
    for (int k = 0; k < 4; k++) exp_q.push_back(base + 32'(4 * k));
    check32({name, " refill_words"}, 32'(addr_log.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check32($sformatf("%s mem_addr%0d", name, k),
              (k < addr_log.size()) ? addr_log[k] : 32'hFFFF_FFFF, exp_q[k]);
  endtask

  // Present an address on the next falling edge and count stall cycles
  // until it hits (bounded), then check the word.
  task automatic fetch(input string name, input logic [31:0] addr,
                       input logic [31:0] exp_data, input int exp_stalls);
    int stalls = 0;
    @(negedge clock);
    ProgAddr = addr;
    #1;
    while (InsCacheStall && stalls < 200) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    checks++;
    if (stalls != exp_stalls) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
    end
    check32({name, " instr"}, Instruction, exp_data);
    if (exp_stalls == 0) check32({name, " mem_req"}, {31'b0, MemReq}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_instr;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[10];

  // ---------------- test ----------------
  initial begin
    int guard;

    vecs[0] = '{RESET_PC, 32'hA0, 5};   // cold start
    vecs[1] = '{32'h14, 32'hA1, 0};     // sequential hits
    vecs[2] = '{32'h18, 32'hA2, 0};
    vecs[3] = '{32'h1C, 32'hA3, 0};
    vecs[4] = '{32'h20, mem_word(32'h20), 5};  // next line, index 2
    vecs[5] = '{32'h2C, mem_word(32'h2C), 0};
    vecs[6] = '{32'h110, 32'hB0, 5};    // conflict on index 1
    vecs[7] = '{32'h11C, 32'hB3, 0};
    vecs[8] = '{32'h10, 32'hA0, 5};     // evicted line misses again
    vecs[9] = '{32'h24, mem_word(32'h24), 0};

    reset    = 1'b1;
    ProgAddr = RESET_PC;
    Flush    = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check32("reset stall", {31'b0, InsCacheStall}, 32'd1);
    check32("reset mem_req", {31'b0, MemReq}, 32'd0);
    check32("reset mem_addr", MemAddr, 32'd0);
    check32("reset instr", Instruction, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      addr_log.delete();
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_stalls);
      if (vecs[i].exp_stalls > 0)
        check_log($sformatf("vec%0d", i), {vecs[i].addr[31:4], 4'h0});
    end

    // Slow memory: three wait cycles per word.
    mem_lat       = 3;
    addr_unstable = 0;
    fetch("slow_miss", 32'h300, mem_word(32'h300), 17);
    check32("slow addr_stable", 32'(addr_unstable), 32'd0);
    fetch("slow_w1", 32'h304, mem_word(32'h304), 0);
    fetch("slow_w2", 32'h308, mem_word(32'h308), 0);
    fetch("slow_w3", 32'h30C, mem_word(32'h30C), 0);
    mem_lat = 0;

    // Flush in IDLE: same-cycle lookup still hits, next cycle misses.
    fetch("pre_flush", 32'h10, 32'hA0, 0);
    @(negedge clock);
    Flush = 1'b1;
    #1;
    check32("idle_flush same_cycle_stall", {31'b0, InsCacheStall}, 32'd0);
    check32("idle_flush same_cycle_instr", Instruction, 32'hA0);
    @(negedge clock);
    Flush = 1'b0;
    #1;
    check32("idle_flush next_stall", {31'b0, InsCacheStall}, 32'd1);
    fetch("idle_flush refill", 32'h10, 32'hA0, 4);
    fetch("refill_20", 32'h20, mem_word(32'h20), 5);
    fetch("refill_300", 32'h300, mem_word(32'h300), 5);

    // Flush during refill, pulsed with the second ack.
    ack_count = 0;
    @(negedge clock);
    ProgAddr = 32'h440;
    guard = 0;
    while (ack_count < 2 && guard < 50) begin
      @(negedge clock);
      #1;
      guard++;
    end
    Flush = 1'b1;
    @(negedge clock);
    Flush = 1'b0;
    #1;
    guard = 0;
    while (MemReq && guard < 50) begin
      @(negedge clock);
      #1;
      guard++;
    end
    check32("flush_refill done", {31'b0, MemReq}, 32'd0);
    check32("flush_refill still_miss", {31'b0, InsCacheStall}, 32'd1);
    fetch("flush_refill again", 32'h440, mem_word(32'h440), 4);
    fetch("flush_refill old_10", 32'h10, 32'hA0, 5);
    fetch("flush_refill old_20", 32'h20, mem_word(32'h20), 5);
    fetch("flush_refill old_300", 32'h300, mem_word(32'h300), 5);

    // Flush together with a miss in IDLE: the new line survives.
    @(negedge clock);
    ProgAddr = 32'h500;
    Flush    = 1'b1;
    #1;
    check32("flush_miss stall", {31'b0, InsCacheStall}, 32'd1);
    @(posedge clock);
    #1 Flush = 1'b0;
    fetch("flush_miss fill", 32'h500, mem_word(32'h500), 4);
    fetch("flush_miss hit", 32'h504, mem_word(32'h504), 0);
    fetch("flush_miss old_10", 32'h10, 32'hA0, 5);

    // Reset after two acks of a refill.
    ack_count = 0;
    @(negedge clock);
    ProgAddr = 32'h608;
    guard = 0;
    while (ack_count < 2 && guard < 50) begin
      @(negedge clock);
      #1;
      guard++;
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check32("mid_reset mem_req", {31'b0, MemReq}, 32'd0);
    check32("mid_reset stall", {31'b0, InsCacheStall}, 32'd1);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    addr_log.delete();
    fetch("mid_reset restart", 32'h608, mem_word(32'h608), 5);
    check_log("mid_reset restart", 32'h600);
    fetch("mid_reset hit", 32'h600, mem_word(32'h600), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
